// File: rtl/sclk_rate_sched.sv
// SPI serial-clock run/stop and rate controller: registered clk_out plus rise/fall enables.
// Rate selects are taken through a one-deep slot (sel_ready low while occupied) and applied at falls.
module sclk_rate_sched #(
  parameter int CNT_W = 8,
  parameter int HALF0 = 2,
  parameter int HALF1 = 1,
  parameter int HALF2 = 4,
  parameter int HALF3 = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sel_in,
  input  logic       sel_valid,
  output logic       sel_ready,
  input  logic       run,
  output logic       clk_out,
  output logic       rise_en,
  output logic       fall_en,
  output logic [1:0] active_sel,
  output logic       busy
);

  if (HALF0 < 1 || HALF0 >= (1 << CNT_W) || HALF1 < 1 || HALF1 >= (1 << CNT_W) ||
      HALF2 < 1 || HALF2 >= (1 << CNT_W) || HALF3 < 1 || HALF3 >= (1 << CNT_W)) begin : g_half_range
    $error("sclk_rate_sched: every HALFn must be in [1, 2**CNT_W)");
  end

  localparam logic [CNT_W-1:0] LAST0 = CNT_W'(HALF0 - 1);
  localparam logic [CNT_W-1:0] LAST1 = CNT_W'(HALF1 - 1);
  localparam logic [CNT_W-1:0] LAST2 = CNT_W'(HALF2 - 1);
  localparam logic [CNT_W-1:0] LAST3 = CNT_W'(HALF3 - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] cnt_last;
  logic             clk_n, rise_n, fall_n, ready_n, busy_n;
  logic [1:0]       sel_n, pend_sel, pend_n;
  logic             accept, wrap;

  always_comb begin
    cnt_last = LAST1;
    case (active_sel)
      2'b00:   cnt_last = LAST0;
      2'b01:   cnt_last = LAST1;
      2'b10:   cnt_last = LAST2;
      default: cnt_last = LAST3;
    endcase
  end

  assign accept = sel_valid & sel_ready;
  assign wrap   = (cnt == cnt_last);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    clk_n   = clk_out;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    sel_n   = active_sel;
    ready_n = sel_ready;
    pend_n  = pend_sel;

    case (state)
      IDLE: begin
        cnt_n = '0;
        clk_n = 1'b0;
        // No period to protect while idle, so selects take effect immediately.
        if (!sel_ready) begin
          sel_n   = pend_sel;
          ready_n = 1'b1;
        end else if (accept) begin
          sel_n = sel_in;
        end
        if (run) state_n = RUN;
      end

      RUN: begin
        if (accept) begin
          pend_n  = sel_in;
          ready_n = 1'b0;
        end
        if (!run && !clk_out) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
          if (wrap) begin
            cnt_n = '0;
            clk_n = ~clk_out;
            if (clk_out) begin
              fall_n = 1'b1;
              if (!sel_ready) begin
                sel_n   = pend_sel;
                ready_n = 1'b1;
              end
            end else begin
              rise_n = 1'b1;
            end
          end
          // run low here implies clk_out high: finish the high phase first.
          if (!run) state_n = wrap ? IDLE : STOPPING;
        end
      end

      STOPPING: begin
        if (accept) begin
          pend_n  = sel_in;
          ready_n = 1'b0;
        end
        cnt_n = cnt + CNT_W'(1);
        if (wrap) begin
          cnt_n   = '0;
          clk_n   = 1'b0;
          fall_n  = 1'b1;
          state_n = IDLE;
          if (!sel_ready) begin
            sel_n   = pend_sel;
            ready_n = 1'b1;
          end
        end
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        clk_n   = 1'b0;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      clk_out    <= 1'b0;
      rise_en    <= 1'b0;
      fall_en    <= 1'b0;
      active_sel <= 2'b01;
      sel_ready  <= 1'b1;
      pend_sel   <= 2'b00;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      clk_out    <= clk_n;
      rise_en    <= rise_n;
      fall_en    <= fall_n;
      active_sel <= sel_n;
      sel_ready  <= ready_n;
      pend_sel   <= pend_n;
      busy       <= busy_n;
    end
  end

endmodule

// File: tb/tb_sclk_rate_sched.sv
// Directed bench for sclk_rate_sched with hand-computed expectations per clock edge.
module tb_sclk_rate_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sel_in;
  logic       sel_valid;
  logic       sel_ready;
  logic       run;
  logic       clk_out;
  logic       rise_en;
  logic       fall_en;
  logic [1:0] active_sel;
  logic       busy;

  int errors = 0;
  int checks = 0;

  sclk_rate_sched dut (
    .clk        (clk),
    .rst        (rst),
    .sel_in     (sel_in),
    .sel_valid  (sel_valid),
    .sel_ready  (sel_ready),
    .run        (run),
    .clk_out    (clk_out),
    .rise_en    (rise_en),
    .fall_en    (fall_en),
    .active_sel (active_sel),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_sel(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of sequence");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; run = 1'b0; sel_valid = 1'b0; sel_in = 2'b00;
    tick(); tick();
    rst = 1'b0;
    chk_bit("rst_clk_out", clk_out, 1'b0);
    chk_bit("rst_rise_en", rise_en, 1'b0);
    chk_bit("rst_fall_en", fall_en, 1'b0);
    chk_bit("rst_sel_ready", sel_ready, 1'b1);
    chk_sel("rst_active_sel", active_sel, 2'b01);
    chk_bit("rst_busy", busy, 1'b0);

    // default rate: half-period of 1 clock
    run = 1'b1;
    tick();
    chk_bit("t2_busy", busy, 1'b1);
    chk_bit("t2_low_first", clk_out, 1'b0);
    tick();
    chk_bit("t2_first_rise", clk_out, 1'b1);
    chk_bit("t2_first_rise_en", rise_en, 1'b1);
    tick();
    chk_bit("t2_first_fall", clk_out, 1'b0);
    chk_bit("t2_first_fall_en", fall_en, 1'b1);
    chk_bit("t2_rise_en_clr", rise_en, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_bit("t2_toggle", clk_out, (i % 2 == 0));
      chk_bit("t2_rise_en", rise_en, (i % 2 == 0));
      chk_bit("t2_fall_en", fall_en, (i % 2 != 0));
    end

    // rate change to sel 10 during run
    sel_valid = 1'b1; sel_in = 2'b10;
    tick();
    sel_valid = 1'b0;
    chk_bit("t3_ready_low", sel_ready, 1'b0);
    chk_sel("t3_sel_held", active_sel, 2'b01);
    chk_bit("t3_rise", clk_out, 1'b1);
    tick();
    chk_sel("t3_sel_applied", active_sel, 2'b10);
    chk_bit("t3_ready_back", sel_ready, 1'b1);
    chk_bit("t3_fall_en", fall_en, 1'b1);
    chk_bit("t3_fall", clk_out, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_bit("t3_low_phase", clk_out, 1'b0);
    end
    tick();
    chk_bit("t3_rise_after4", clk_out, 1'b1);
    chk_bit("t3_rise_en", rise_en, 1'b1);
    tick();
    chk_bit("t4_high", clk_out, 1'b1);
    chk_bit("t4_rise_en_clr", rise_en, 1'b0);

    // stop during high phase: finish the high phase
    run = 1'b0;
    tick();
    chk_bit("t4_stop_high1", clk_out, 1'b1);
    chk_bit("t4_stop_busy", busy, 1'b1);
    tick();
    chk_bit("t4_stop_high2", clk_out, 1'b1);
    chk_bit("t4_stop_no_fall", fall_en, 1'b0);
    tick();
    chk_bit("t4_stop_fall", clk_out, 1'b0);
    chk_bit("t4_stop_fall_en", fall_en, 1'b1);
    tick();
    chk_bit("t4_idle_busy", busy, 1'b0);
    chk_bit("t4_idle_fall_en", fall_en, 1'b0);

    // back-to-back selects while one is pending
    run = 1'b1;
    tick();
    sel_valid = 1'b1; sel_in = 2'b00;
    tick();
    sel_in = 2'b10;
    chk_bit("t5_pending", sel_ready, 1'b0);
    chk_sel("t5_sel_held", active_sel, 2'b10);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_bit("t5_still_pending", sel_ready, 1'b0);
      chk_sel("t5_still_held", active_sel, 2'b10);
    end
    tick();
    chk_sel("t5_first_applied", active_sel, 2'b00);
    chk_bit("t5_ready_back", sel_ready, 1'b1);
    chk_bit("t5_fall_en", fall_en, 1'b1);
    tick();
    chk_bit("t5_second_taken", sel_ready, 1'b0);
    chk_sel("t5_rate00", active_sel, 2'b00);
    sel_valid = 1'b0;
    tick();
    chk_bit("t5_rise_half2", clk_out, 1'b1);
    chk_bit("t5_rise_en", rise_en, 1'b1);
    tick();
    chk_bit("t5_high_half2", clk_out, 1'b1);
    tick();
    chk_bit("t5_fall_half2", clk_out, 1'b0);
    chk_bit("t5_fall_en2", fall_en, 1'b1);
    chk_sel("t5_final_sel", active_sel, 2'b10);
    chk_bit("t5_ready_final", sel_ready, 1'b1);

    // stop during low phase: straight to idle, no fall pulse
    run = 1'b0;
    tick();
    chk_bit("t5_low_stop_busy", busy, 1'b0);
    chk_bit("t5_low_stop_fall_en", fall_en, 1'b0);
    chk_bit("t5_low_stop_clk", clk_out, 1'b0);

    // selects in idle, including one together with run
    sel_valid = 1'b1; sel_in = 2'b01;
    tick();
    chk_sel("t6_idle_sel", active_sel, 2'b01);
    chk_bit("t6_idle_ready", sel_ready, 1'b1);
    sel_in = 2'b10; run = 1'b1;
    tick();
    sel_valid = 1'b0;
    chk_sel("t6_sel_with_run", active_sel, 2'b10);
    chk_bit("t6_busy", busy, 1'b1);
    chk_bit("t6_low", clk_out, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_bit("t6_low_phase", clk_out, 1'b0);
    end
    tick();
    chk_bit("t6_rise", clk_out, 1'b1);
    chk_bit("t6_rise_en", rise_en, 1'b1);

    // asynchronous reset mid-stream with a select pending
    sel_valid = 1'b1; sel_in = 2'b00;
    tick();
    sel_valid = 1'b0;
    chk_bit("t1_pending", sel_ready, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_bit("t1_async_clk_out", clk_out, 1'b0);
    chk_bit("t1_async_busy", busy, 1'b0);
    chk_bit("t1_async_ready", sel_ready, 1'b1);
    chk_sel("t1_async_sel", active_sel, 2'b01);
    chk_bit("t1_async_rise_en", rise_en, 1'b0);
    #1 rst = 1'b0;
    tick();
    tick();
    chk_bit("t1_restart_rise", clk_out, 1'b1);
    tick();
    chk_bit("t1_restart_fall", fall_en, 1'b1);
    chk_sel("t1_pending_dropped", active_sel, 2'b01);
    chk_bit("t1_ready_after", sel_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
